// File: rtl/random_engine_pkg.sv
// Shared types and defaults for the random-engine burst scheduler.
// Included by the arbiter, its round-robin picker and the register helper users.
package random_engine_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    localparam int NBITS_DEF = 32;
    localparam int LEN_W_DEF = 8;

    // Index width for n requesters, never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/random_engine_arb_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, with wrap.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any_val
);

    int cand_s;

    // Scan upward from the pointer; the first hit wins and later hits are ignored.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_val = 1'b0;
        cand_s  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = (int'(ptr) + k) % NREQ;
            if (!any_val && req[cand_s]) begin
                gnt[cand_s] = 1'b1;
                gnt_idx     = IDW'(cand_s);
                any_val     = 1'b1;
            end else begin
                any_val = any_val;
            end
        end
    end

endmodule

// File: rtl/register.sv
// Generic enabled register with synchronous active-low reset.
module register #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Storage element: reset wins, otherwise load when enabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/random_engine_arb.sv
// Shares one LFSR datapath between NREQ burst requesters; seed loads win while idle,
// requests are granted round-robin and each consumed word advances the LFSR once.
module random_engine_arb
    import random_engine_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int NBITS = NBITS_DEF,
    parameter int LEN_W = LEN_W_DEF,
    localparam int IDW  = id_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_val,
    input  logic [NREQ*LEN_W-1:0] req_len,
    output logic [NREQ-1:0]       req_rdy,
    input  logic                  seed_val,
    input  logic [NBITS-1:0]      seed,
    output logic                  seed_rdy,
    output logic                  resp_val,
    input  logic                  resp_rdy,
    output logic [IDW-1:0]        resp_id,
    output logic [NBITS-1:0]      resp_data,
    input  logic [NBITS-1:0]      lfsr_q,
    output logic                  lfsr_en,
    output logic                  lfsr_ld,
    output logic [NBITS-1:0]      lfsr_seed,
    output logic                  busy
);

    logic              state_q_s;
    state_e            state_d_s;
    logic [IDW-1:0]    ptr_q_s;
    logic [IDW-1:0]    ptr_d_s;
    logic [LEN_W-1:0]  count_q_s;
    logic [LEN_W-1:0]  count_d_s;
    logic [IDW-1:0]    owner_q_s;
    logic [NREQ-1:0]   gnt_vec_s;
    logic [IDW-1:0]    gnt_idx_s;
    logic              any_val_s;
    logic              idle_s;
    logic              burst_s;
    logic              seed_take_s;
    logic              grant_s;
    logic              hs_s;
    logic [LEN_W-1:0]  len_sel_s;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .req     (req_val),
        .ptr     (ptr_q_s),
        .gnt     (gnt_vec_s),
        .gnt_idx (gnt_idx_s),
        .any_val (any_val_s)
    );

    assign idle_s      = (state_q_s == IDLE);
    assign burst_s     = (state_q_s == BURST);
    assign seed_take_s = idle_s && seed_val;
    assign grant_s     = idle_s && !seed_val && any_val_s;
    assign hs_s        = burst_s && resp_rdy;
    assign len_sel_s   = req_len[gnt_idx_s*LEN_W +: LEN_W];

    // Next-state, pointer and counter updates; a zero-length grant never leaves IDLE.
    always_comb begin
        state_d_s = state_e'(state_q_s);
        ptr_d_s   = ptr_q_s;
        count_d_s = count_q_s;
        case (state_e'(state_q_s))
            IDLE: begin
                if (grant_s && (len_sel_s != '0)) begin
                    state_d_s = BURST;
                end else begin
                    state_d_s = IDLE;
                end
            end
            BURST: begin
                if (hs_s && (count_q_s == LEN_W'(1))) begin
                    state_d_s = IDLE;
                end else begin
                    state_d_s = BURST;
                end
            end
            default: state_d_s = IDLE;
        endcase
        if (gnt_idx_s == IDW'(NREQ - 1)) begin
            ptr_d_s = '0;
        end else begin
            ptr_d_s = gnt_idx_s + 1'b1;
        end
        if (grant_s) begin
            count_d_s = len_sel_s;
        end else begin
            count_d_s = count_q_s - LEN_W'(1);
        end
    end

    register #(.WIDTH(1)) u_state (
        .clk (clk), .rst (rst), .en (1'b1), .d (state_d_s), .q (state_q_s)
    );

    register #(.WIDTH(IDW)) u_ptr (
        .clk (clk), .rst (rst), .en (grant_s), .d (ptr_d_s), .q (ptr_q_s)
    );

    register #(.WIDTH(LEN_W)) u_count (
        .clk (clk), .rst (rst), .en (grant_s || hs_s), .d (count_d_s), .q (count_q_s)
    );

    register #(.WIDTH(IDW)) u_owner (
        .clk (clk), .rst (rst), .en (grant_s), .d (gnt_idx_s), .q (owner_q_s)
    );

    // Handshake outputs are gated by rst so nothing leaks out during the reset cycle.
    assign req_rdy   = (rst && grant_s) ? gnt_vec_s : '0;
    assign seed_rdy  = rst && seed_take_s;
    assign lfsr_ld   = rst && seed_take_s;
    assign lfsr_seed = seed;
    assign resp_val  = rst && burst_s;
    assign busy      = rst && burst_s;
    assign lfsr_en   = rst && hs_s;
    assign resp_id   = (rst && burst_s) ? owner_q_s : '0;
    assign resp_data = lfsr_q;

endmodule
